xvga_timing: RTL and testbench
==============================

XVGA_TIMING -- requirements
Module: xvga_timing

Interface
REQ-001 Parameter H_ACTIVE, default 1024, visible pixels per line.
REQ-002 Parameter H_FP, default 24, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 136, horizontal sync width in pixels.
REQ-004 Parameter H_BP, default 160, horizontal back porch in pixels.
REQ-005 Parameter V_ACTIVE, default 768, visible lines per frame.
REQ-006 Parameter V_FP, default 3, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 6, vertical sync width in lines.
REQ-008 Parameter V_BP, default 29, vertical back porch in lines.
REQ-009 Parameter PIPE_DELAY, default 1, range 1..4, downstream pixel latency in cycles.
REQ-010 pixel_clk  input  1  sole clock; all state updates on its rising edge.
REQ-011 reset  input  1  synchronous, active-high reset.
REQ-012 hcount  output  11  current pixel column, 0..H_TOTAL-1 (H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 1344).
REQ-013 vcount  output  10  current line, 0..V_TOTAL-1 (V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 806).
REQ-014 hsync  output  1  active-low horizontal sync, aligned with hcount/vcount.
REQ-015 vsync  output  1  active-low vertical sync, aligned with hcount/vcount.
REQ-016 blank  output  1  high outside the visible area, aligned with hcount/vcount.
REQ-017 hsync_d, vsync_d, blank_d  output  1 each  hsync/vsync/blank delayed by exactly PIPE_DELAY cycles, for alignment with the 1-cycle-registered pixel from picture blob stages.
REQ-018 frame_start  output  1  single-cycle pulse marking the first pixel of a new frame.

Function
REQ-019 hcount SHALL increment by 1 every cycle and wrap from H_TOTAL-1 to 0.
REQ-020 vcount SHALL increment by 1 only on cycles where hcount = H_TOTAL-1, wrapping from V_TOTAL-1 to 0 on that same cycle.
REQ-021 hsync SHALL be 0 exactly while hcount is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [1048,1183], else 1.
REQ-022 vsync SHALL be 0 exactly while vcount is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [771,776], else 1, changing on the same cycle as vcount.
REQ-023 blank SHALL be 1 iff hcount >= H_ACTIVE or vcount >= V_ACTIVE.
REQ-024 hsync, vsync, blank SHALL be registered outputs computed from the next counter values, so they have zero-cycle skew against hcount/vcount.
REQ-025 The *_d outputs SHALL be produced by a PIPE_DELAY-deep register shift chain; no combinational path from counters to *_d.
REQ-026 frame_start SHALL be 1 only on the cycle where hcount=0 and vcount=0 as a result of a wrap from (H_TOTAL-1, V_TOTAL-1); never as a result of reset.
REQ-027 Counter arithmetic SHALL be unsigned, native width; no value outside the ranges in REQ-012/013 SHALL ever appear.

Reset
REQ-028 While reset is 1 at a rising edge: hcount=0, vcount=0, hsync=1, vsync=1, blank=0, frame_start=0.
REQ-029 While reset is 1: every stage of the delay chain SHALL load hsync_d=1, vsync_d=1, blank_d=1.
REQ-030 Reset asserted mid-line or mid-frame SHALL take effect on the next edge with no partial-line completion; counting resumes at (0,0) on the first edge after release.
REQ-031 For PIPE_DELAY cycles after reset release, *_d SHALL show the reset values before tracking the delayed signals.

Structure
REQ-032 Timing defaults, H_TOTAL, V_TOTAL and sync-window bounds SHALL live in a shared video timing package reused by picture blob and display top.
REQ-033 One sub-module, sync_delay_line (parameterized width and depth, reset value input), SHALL implement REQ-025.

Verification
REQ-034 Release reset, run 1344 cycles -> hcount 0..1343 then 0; vcount steps 0->1 on the cycle hcount reads 0.
REQ-035 Run one full frame (1,083,264 cycles) -> exactly one frame_start, coincident with (0,0); hsync low 136 cycles per line; vsync low for 6 lines (8064 cycles).
REQ-036 Check at (1023,767) blank=0, (1024,767) blank=1, (0,768) blank=1, (1343,805)->(0,0) blank returns 0.
REQ-037 PIPE_DELAY=1 and 3 -> hsync_d/vsync_d/blank_d equal hsync/vsync/blank sampled 1 and 3 cycles earlier; reset values for the first 1 or 3 cycles after release.
REQ-038 Assert reset at (600,400) for 2 cycles -> next edge outputs (0,0), hsync=vsync=1, frame_start stays 0; first frame_start 1,083,264 cycles after release.

Source files
------------

// File: rtl/xvga_timing_pkg.sv
// Shared video timing package.
// Holds the default XVGA (1024x768) timing, the derived line/frame totals and sync-window
// bounds, the counter widths, and small helpers. The raster generator, picture blob stages
// and the display top all import this package so they agree on one set of numbers.
package xvga_timing_pkg;

  // Default horizontal timing, in pixels
  localparam int unsigned DEF_H_ACTIVE = 1024;
  localparam int unsigned DEF_H_FP     = 24;
  localparam int unsigned DEF_H_SYNC   = 136;
  localparam int unsigned DEF_H_BP     = 160;

  // Default vertical timing, in lines
  localparam int unsigned DEF_V_ACTIVE = 768;
  localparam int unsigned DEF_V_FP     = 3;
  localparam int unsigned DEF_V_SYNC   = 6;
  localparam int unsigned DEF_V_BP     = 29;

  localparam int unsigned DEF_PIPE_DELAY = 1;

  localparam int unsigned DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Sync windows, inclusive bounds
  localparam int unsigned DEF_HSYNC_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int unsigned DEF_HSYNC_END   = DEF_HSYNC_START + DEF_H_SYNC - 1;
  localparam int unsigned DEF_VSYNC_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int unsigned DEF_VSYNC_END   = DEF_VSYNC_START + DEF_V_SYNC - 1;

  // Counter port widths are fixed by the display interface
  localparam int unsigned HCOUNT_W = 11;
  localparam int unsigned VCOUNT_W = 10;

  typedef logic [HCOUNT_W-1:0] hcount_t;
  typedef logic [VCOUNT_W-1:0] vcount_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic blank;
  } sync_bits_t;

  // Value of the aligned sync outputs while in reset: (0,0) is a visible pixel
  localparam sync_bits_t SYNC_RST  = '{hsync: 1'b1, vsync: 1'b1, blank: 1'b0};
  // Delay chain parks everything inactive, including blank
  localparam sync_bits_t DELAY_RST = '{hsync: 1'b1, vsync: 1'b1, blank: 1'b1};

  function automatic int unsigned timing_total(input int unsigned active,
                                               input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  // True when value lies in [start, start+len-1]
  function automatic logic in_window(input int unsigned value,
                                     input int unsigned start,
                                     input int unsigned len);
    return (value >= start) && (value < start + len);
  endfunction

endpackage

// File: rtl/xvga_timing_sync_delay_line.sv
// sync_delay_line: fixed-latency register shift chain for sync/blank bits.
// Ports:
//   pixel_clk  in   clock
//   reset      in   synchronous active-high reset; every stage loads reset_val
//   reset_val  in   [Width]  value parked in all stages during reset
//   din        in   [Width]  chain input
//   dout       out  [Width]  din delayed by exactly Depth cycles (registered, no comb path)
module sync_delay_line #(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = 1
) (
  input  logic             pixel_clk,
  input  logic             reset,
  input  logic [Width-1:0] reset_val,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout
);

  logic [Width-1:0] stage_q [Depth];

  for (genvar g = 0; g < Depth; g++) begin : g_stage
    if (g == 0) begin : g_head
      always_ff @(posedge pixel_clk) begin
        if (reset) begin
          stage_q[g] <= reset_val;
        end else begin
          stage_q[g] <= din;
        end
      end
    end else begin : g_tail
      always_ff @(posedge pixel_clk) begin
        if (reset) begin
          stage_q[g] <= reset_val;
        end else begin
          stage_q[g] <= stage_q[g-1];
        end
      end
    end
  end

  assign dout = stage_q[Depth-1];

endmodule

// File: rtl/xvga_timing.sv
// xvga_timing: raster counter and sync generator for a parameterised VGA-style timing.
// Ports:
//   pixel_clk    in   sole clock
//   reset        in   synchronous active-high reset
//   hcount       out  [11] pixel column, 0..H_TOTAL-1
//   vcount       out  [10] line, 0..V_TOTAL-1
//   hsync        out  active-low horizontal sync, aligned with hcount/vcount
//   vsync        out  active-low vertical sync, aligned with hcount/vcount
//   blank        out  high outside the visible area, aligned with hcount/vcount
//   hsync_d      out  hsync delayed PIPE_DELAY cycles
//   vsync_d      out  vsync delayed PIPE_DELAY cycles
//   blank_d      out  blank delayed PIPE_DELAY cycles
//   frame_start  out  one-cycle pulse on the (0,0) reached by wrapping, never after reset
// PIPE_DELAY must be in 1..4.
module xvga_timing
  import xvga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned H_FP       = DEF_H_FP,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BP       = DEF_H_BP,
  parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
  parameter int unsigned V_FP       = DEF_V_FP,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BP       = DEF_V_BP,
  parameter int unsigned PIPE_DELAY = DEF_PIPE_DELAY
) (
  input  logic                pixel_clk,
  input  logic                reset,
  output logic [HCOUNT_W-1:0] hcount,
  output logic [VCOUNT_W-1:0] vcount,
  output logic                hsync,
  output logic                vsync,
  output logic                blank,
  output logic                hsync_d,
  output logic                vsync_d,
  output logic                blank_d,
  output logic                frame_start
);

  localparam int unsigned H_TOTAL     = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL     = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned HSYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned VSYNC_START = V_ACTIVE + V_FP;

  hcount_t    hcount_q, hcount_d;
  vcount_t    vcount_q, vcount_d;
  sync_bits_t sync_q, sync_d;
  sync_bits_t sync_delayed;
  logic       frame_start_q;
  logic       h_last, v_last;

  always_comb begin
    h_last   = (hcount_q == hcount_t'(H_TOTAL - 1));
    v_last   = (vcount_q == vcount_t'(V_TOTAL - 1));
    hcount_d = h_last ? '0 : hcount_q + hcount_t'(1);
    vcount_d = vcount_q;
    if (h_last) begin
      vcount_d = v_last ? '0 : vcount_q + vcount_t'(1);
    end
    // Decode from the next counter values so the registered flags land with the counters
    sync_d.hsync = ~in_window(32'(hcount_d), HSYNC_START, H_SYNC);
    sync_d.vsync = ~in_window(32'(vcount_d), VSYNC_START, V_SYNC);
    sync_d.blank = (32'(hcount_d) >= H_ACTIVE) || (32'(vcount_d) >= V_ACTIVE);
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      sync_q        <= SYNC_RST;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      sync_q        <= sync_d;
      frame_start_q <= h_last && v_last;
    end
  end

  sync_delay_line #(
    .Width ($bits(sync_bits_t)),
    .Depth (PIPE_DELAY)
  ) u_sync_delay_line (
    .pixel_clk (pixel_clk),
    .reset     (reset),
    .reset_val (DELAY_RST),
    .din       (sync_q),
    .dout      (sync_delayed)
  );

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign hsync       = sync_q.hsync;
  assign vsync       = sync_q.vsync;
  assign blank       = sync_q.blank;
  assign hsync_d     = sync_delayed.hsync;
  assign vsync_d     = sync_delayed.vsync;
  assign blank_d     = sync_delayed.blank;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_xvga_timing.sv
// Bench for xvga_timing using a shrunken raster so whole frames fit in a short run:
// 16 pixels per line (8 visible, hsync at 10..12), 9 lines per frame (4 visible,
// vsync on lines 5..6), 144 cycles per frame. Two instances cover PIPE_DELAY 1 and 3.
module tb_xvga_timing;

  localparam int unsigned HT    = 16;
  localparam int unsigned VT    = 9;
  localparam int unsigned FRAME = HT * VT;

  logic        clk;
  logic        reset;
  logic [10:0] hc1, hc3;
  logic [9:0]  vc1, vc3;
  logic        hs1, vs1, bl1, hsd1, vsd1, bld1, fs1;
  logic        hs3, vs3, bl3, hsd3, vsd3, bld3, fs3;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  xvga_timing #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (2),
    .PIPE_DELAY (1)
  ) dut1 (
    .pixel_clk (clk), .reset (reset), .hcount (hc1), .vcount (vc1),
    .hsync (hs1), .vsync (vs1), .blank (bl1),
    .hsync_d (hsd1), .vsync_d (vsd1), .blank_d (bld1), .frame_start (fs1)
  );

  xvga_timing #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (2),
    .PIPE_DELAY (3)
  ) dut3 (
    .pixel_clk (clk), .reset (reset), .hcount (hc3), .vcount (vc3),
    .hsync (hs3), .vsync (vs3), .blank (bl3),
    .hsync_d (hsd3), .vsync_d (vsd3), .blank_d (bld3), .frame_start (fs3)
  );

  typedef struct {
    logic        rst;
    int unsigned cyc;
    int unsigned h;
    int unsigned v;
    logic        hs;
    logic        vs;
    logic        bl;
    logic        fs;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input int unsigned cyc, input int unsigned h,
                     input int unsigned v, input logic hs, input logic vs, input logic bl,
                     input logic fs);
    vec_t r;
    r.rst = rst; r.cyc = cyc; r.h = h; r.v = v;
    r.hs = hs; r.vs = vs; r.bl = bl; r.fs = fs;
    vecs.push_back(r);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected {hsync, vsync, blank} t cycles after the last reset edge
  function automatic logic [2:0] exp_sync(input int unsigned t);
    int unsigned h, v;
    h = t % HT;
    v = (t / HT) % VT;
    return {!(h >= 10 && h <= 12), !(v >= 5 && v <= 6), (h >= 8 || v >= 4)};
  endfunction

  function automatic logic [2:0] exp_delayed(input int unsigned t, input int unsigned d);
    if (t < d) return 3'b111;
    return exp_sync(t - d);
  endfunction

  initial begin
    int unsigned fs_count, hs_low, vs_low;

    reset = 1'b1;

    //   rst  cyc  h   v  hs vs bl fs
    add(1, 2,   0,  0, 1, 1, 0, 0);  // reset state
    add(0, 7,   7,  0, 1, 1, 0, 0);  // last visible pixel of line 0
    add(0, 1,   8,  0, 1, 1, 1, 0);  // first blanked pixel
    add(0, 2,  10,  0, 0, 1, 1, 0);  // hsync start
    add(0, 2,  12,  0, 0, 1, 1, 0);  // hsync last
    add(0, 1,  13,  0, 1, 1, 1, 0);  // hsync ends
    add(0, 2,  15,  0, 1, 1, 1, 0);  // end of line
    add(0, 1,   0,  1, 1, 1, 0, 0);  // vcount steps with hcount wrap
    add(0, 39,  7,  3, 1, 1, 0, 0);  // last visible pixel of frame
    add(0, 1,   8,  3, 1, 1, 1, 0);
    add(0, 8,   0,  4, 1, 1, 1, 0);  // first blanked line
    add(0, 16,  0,  5, 1, 0, 1, 0);  // vsync starts with vcount
    add(0, 27, 11,  6, 0, 0, 1, 0);  // both syncs low
    add(0, 5,   0,  7, 1, 1, 1, 0);  // vsync ends
    add(0, 31, 15,  8, 1, 1, 1, 0);  // last pixel of frame
    add(0, 1,   0,  0, 1, 1, 0, 1);  // wrap: frame_start
    add(0, 1,   1,  0, 1, 1, 0, 0);  // single-cycle pulse
    add(0, 36,  5,  2, 1, 1, 0, 0);  // mid-frame
    add(1, 1,   0,  0, 1, 1, 0, 0);  // reset mid-line, no frame_start
    add(1, 1,   0,  0, 1, 1, 0, 0);
    add(0, 1,   1,  0, 1, 1, 0, 0);  // resumes counting
    add(0, 90, 11,  5, 0, 0, 1, 0);  // inside both sync windows
    add(1, 1,   0,  0, 1, 1, 0, 0);  // reset forces syncs inactive

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst;
      step(vecs[i].cyc);
      check($sformatf("vec%0d.hcount", i), 32'(hc1), vecs[i].h);
      check($sformatf("vec%0d.vcount", i), 32'(vc1), vecs[i].v);
      check($sformatf("vec%0d.hsync", i), 32'(hs1), 32'(vecs[i].hs));
      check($sformatf("vec%0d.vsync", i), 32'(vs1), 32'(vecs[i].vs));
      check($sformatf("vec%0d.blank", i), 32'(bl1), 32'(vecs[i].bl));
      check($sformatf("vec%0d.frame_start", i), 32'(fs1), 32'(vecs[i].fs));
    end

    // Reset values on the delay chains while reset is held
    reset = 1'b1;
    step(2);
    check("rst.d1", 32'({hsd1, vsd1, bld1}), 32'(3'b111));
    check("rst.d3", 32'({hsd3, vsd3, bld3}), 32'(3'b111));

    // Two full frames after release, every output against the cycle model
    reset = 1'b0;
    fs_count = 0;
    hs_low   = 0;
    vs_low   = 0;
    for (int unsigned t = 0; t < 2 * FRAME + 5; t++) begin
      if (t > 0) step(1);
      check($sformatf("t%0d.hcount", t), 32'(hc1), t % HT);
      check($sformatf("t%0d.vcount", t), 32'(vc1), (t / HT) % VT);
      check($sformatf("t%0d.sync", t), 32'({hs1, vs1, bl1}), 32'(exp_sync(t)));
      check($sformatf("t%0d.frame_start", t), 32'(fs1), 32'(t > 0 && t % FRAME == 0));
      check($sformatf("t%0d.d1", t), 32'({hsd1, vsd1, bld1}), 32'(exp_delayed(t, 1)));
      check($sformatf("t%0d.hcount3", t), 32'(hc3), t % HT);
      check($sformatf("t%0d.sync3", t), 32'({hs3, vs3, bl3}), 32'(exp_sync(t)));
      check($sformatf("t%0d.d3", t), 32'({hsd3, vsd3, bld3}), 32'(exp_delayed(t, 3)));
      if (fs1) fs_count++;
      if (t < HT && !hs1) hs_low++;
      if (t < FRAME && !vs1) vs_low++;
    end
    check("frame_start.count", fs_count, 2);
    check("hsync.low_per_line", hs_low, 3);
    check("vsync.low_per_frame", vs_low, 2 * HT);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
